// File: rtl/strb_window_sample_buffer.sv
// strb_window_sample_buffer
//   Captures one ADC channel's samples while store_strb is high, removes the
//   channel's fixed front-end bit inversion, holds the window in a local buffer
//   and then drains it as a valid/ready stream towards the readout packer.
//
// Ports
//   i_clk357         357 MHz sample clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_store_strb     capture window, high while samples are valid
//   i_data_in        raw channel sample (bit-inverted per BITFLIP)
//   i_flags_clr      single-cycle pulse clearing overflow / missed_trig
//   i_rd_ready       downstream accepts o_rd_data this cycle
//   o_rd_valid       o_rd_data holds a stored sample
//   o_rd_data        corrected sample, two's complement
//   o_rd_last        with o_rd_valid: final sample of the window
//   o_sample_count   samples captured in the last / current window
//   o_trig_count     windows accepted since reset (wraps)
//   o_overflow       sticky: a window exceeded DEPTH samples
//   o_missed_trig    sticky: a window started while draining
//   o_busy           high while storing or draining
module strb_window_sample_buffer #(
  parameter int unsigned        DATA_W  = 13,
  parameter logic [DATA_W-1:0]  BITFLIP = '0,
  parameter int unsigned        DEPTH   = 164,
  parameter int unsigned        ADDR_W  = 8
) (
  input  logic                     i_clk357,
  input  logic                     i_rst_n,
  input  logic                     i_store_strb,
  input  logic [DATA_W-1:0]        i_data_in,
  input  logic                     i_flags_clr,
  input  logic                     i_rd_ready,
  output logic                     o_rd_valid,
  output logic signed [DATA_W-1:0] o_rd_data,
  output logic                     o_rd_last,
  output logic [ADDR_W:0]          o_sample_count,
  output logic [15:0]              o_trig_count,
  output logic                     o_overflow,
  output logic                     o_missed_trig,
  output logic                     o_busy
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StStore, StDrain} state_e;

  state_e              r_state;
  logic [DATA_W-1:0]   r_din_q;
  logic                r_strb_q;
  logic                r_strb_qq;
  // Write pointer doubles as the live sample count of the window.
  logic [ADDR_W:0]     r_wr_ptr;
  logic [ADDR_W:0]     r_fetch_ptr;
  // Stage 1: registered buffer read; stage 2: output (prefetch) register.
  logic [DATA_W-1:0]   r_mem_q;
  logic                r_mem_vld;
  logic                r_mem_last;
  logic                r_rd_valid;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_last;
  logic [15:0]         r_trig_count;
  logic                r_overflow;
  logic                r_missed;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_rise;
  logic                w_xfer;
  logic                w_s1_take;
  logic                w_fetch;
  logic                w_wr_en;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [ADDR_W:0]     w_last_idx;

  assign w_rise     = r_strb_q & ~r_strb_qq;
  assign w_xfer     = r_rd_valid & i_rd_ready;
  // Stage 1 moves into the output register when that register is empty or emptying.
  assign w_s1_take  = r_mem_vld & (~r_rd_valid | w_xfer);
  assign w_fetch    = (r_state == StDrain) && (r_fetch_ptr < r_wr_ptr) &&
                      (~r_mem_vld || w_s1_take);
  assign w_wr_en    = ((r_state == StIdle) && w_rise) ||
                      ((r_state == StStore) && r_strb_q && (r_wr_ptr < DEPTH_C));
  assign w_wr_addr  = (r_state == StIdle) ? '0 : r_wr_ptr[ADDR_W-1:0];
  assign w_last_idx = r_wr_ptr - 1'b1;

  // Sample buffer: no reset, contents are only meaningful below r_wr_ptr.
  always_ff @(posedge i_clk357) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= r_din_q;
    end
  end

  always_ff @(posedge i_clk357 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_din_q      <= '0;
      r_strb_q     <= 1'b0;
      r_strb_qq    <= 1'b0;
      r_wr_ptr     <= '0;
      r_fetch_ptr  <= '0;
      r_mem_q      <= '0;
      r_mem_vld    <= 1'b0;
      r_mem_last   <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_rd_last    <= 1'b0;
      r_trig_count <= '0;
      r_overflow   <= 1'b0;
      r_missed     <= 1'b0;
    end else begin
      r_din_q   <= i_data_in ^ BITFLIP;
      r_strb_q  <= i_store_strb;
      r_strb_qq <= r_strb_q;

      // Clear first so a set in the same cycle (below) takes priority.
      if (i_flags_clr) begin
        r_overflow <= 1'b0;
        r_missed   <= 1'b0;
      end

      if (w_fetch) begin
        r_mem_q     <= r_mem[r_fetch_ptr[ADDR_W-1:0]];
        r_mem_last  <= (r_fetch_ptr == w_last_idx);
        r_fetch_ptr <= r_fetch_ptr + 1'b1;
        r_mem_vld   <= 1'b1;
      end else if (w_s1_take) begin
        r_mem_vld <= 1'b0;
      end

      if (w_s1_take) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= r_mem_q;
        r_rd_last  <= r_mem_last;
      end else if (w_xfer) begin
        r_rd_valid <= 1'b0;
      end

      unique case (r_state)
        StIdle: begin
          if (w_rise) begin
            r_state      <= StStore;
            r_wr_ptr     <= (ADDR_W + 1)'(1);
            r_trig_count <= r_trig_count + 1'b1;
          end
        end
        StStore: begin
          if (r_strb_q) begin
            if (r_wr_ptr < DEPTH_C) begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end else begin
              r_overflow <= 1'b1;
            end
          end else begin
            r_state     <= StDrain;
            r_fetch_ptr <= '0;
            r_mem_vld   <= 1'b0;
          end
        end
        StDrain: begin
          if (w_rise) begin
            r_missed <= 1'b1;
          end
          if (w_xfer && r_rd_last) begin
            r_state    <= StIdle;
            r_rd_valid <= 1'b0;
            r_mem_vld  <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_rd_valid     = r_rd_valid;
  assign o_rd_data      = r_rd_data;
  assign o_rd_last      = r_rd_last;
  assign o_sample_count = r_wr_ptr;
  assign o_trig_count   = r_trig_count;
  assign o_overflow     = r_overflow;
  assign o_missed_trig  = r_missed;
  assign o_busy         = (r_state != StIdle);

endmodule

// File: tb/tb_strb_window_sample_buffer.sv
// tb_strb_window_sample_buffer
//   Directed bench for strb_window_sample_buffer: constant and ramp windows,
//   overflow, stalled drain, missed trigger, mid-window reset, trig_count wrap.
`timescale 1ns/1ps
module tb_strb_window_sample_buffer;

  localparam int unsigned DATA_W = 13;
  localparam int unsigned DEPTH  = 164;
  localparam int unsigned ADDR_W = 8;
  localparam logic [12:0] FLIP   = 13'h1685;

  logic        clk357     = 1'b0;
  logic        rst_n      = 1'b0;
  logic        store_strb = 1'b0;
  logic [12:0] data_in    = '0;
  logic        flags_clr  = 1'b0;
  logic        rd_ready   = 1'b0;
  logic        rd_valid;
  logic [12:0] rd_data;
  logic        rd_last;
  logic [8:0]  sample_count;
  logic [15:0] trig_count;
  logic        overflow;
  logic        missed_trig;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [12:0] exp_mem [256];

  strb_window_sample_buffer #(
    .DATA_W  (DATA_W),
    .BITFLIP (FLIP),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) dut (
    .i_clk357       (clk357),
    .i_rst_n        (rst_n),
    .i_store_strb   (store_strb),
    .i_data_in      (data_in),
    .i_flags_clr    (flags_clr),
    .i_rd_ready     (rd_ready),
    .o_rd_valid     (rd_valid),
    .o_rd_data      (rd_data),
    .o_rd_last      (rd_last),
    .o_sample_count (sample_count),
    .o_trig_count   (trig_count),
    .o_overflow     (overflow),
    .o_missed_trig  (missed_trig),
    .o_busy         (busy)
  );

  always #5 clk357 = ~clk357;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  // Drives n samples; ramp gives base+i, otherwise constant base (corrected values).
  task automatic send_window(input int n, input bit ramp, input logic [12:0] base);
    logic [12:0] raw;
    for (int i = 0; i < n; i++) begin
      @(negedge clk357);
      raw        = ramp ? base + 13'(i) : base;
      store_strb = 1'b1;
      data_in    = raw ^ FLIP;
      if (i < int'(DEPTH)) exp_mem[i] = raw;
    end
    @(negedge clk357);
    store_strb = 1'b0;
    data_in    = '0;
  endtask

  // Collects n samples with rd_ready following pat (bit cyc%4); optional strobe
  // pulse of 3 cycles starting at cycle pulse_at.
  task automatic drain(input int n, input logic [3:0] pat, input int pulse_at,
                       input string tag);
    int          got_n = 0;
    int          cyc   = 0;
    logic        pv    = 1'b0;
    logic        pr    = 1'b0;
    logic        pl    = 1'b0;
    logic [12:0] pd    = '0;
    while (got_n < n && cyc < 4 * n + 40) begin
      @(negedge clk357);
      if (pv && !pr) begin
        check({tag, "_stall_valid"}, 32'(rd_valid), 32'd1);
        check({tag, "_stall_data"}, 32'(rd_data), 32'(pd));
        check({tag, "_stall_last"}, 32'(rd_last), 32'(pl));
      end
      rd_ready   = pat[cyc % 4];
      store_strb = (pulse_at >= 0) && (cyc >= pulse_at) && (cyc < pulse_at + 3);
      if (rd_valid && rd_ready) begin
        check({tag, "_data"}, 32'(rd_data), 32'(exp_mem[got_n]));
        check({tag, "_last"}, 32'(rd_last), 32'(got_n == n - 1));
        got_n++;
      end
      pv = rd_valid;
      pr = rd_ready;
      pd = rd_data;
      pl = rd_last;
      cyc++;
    end
    check({tag, "_count"}, 32'(got_n), 32'(n));
    @(negedge clk357);
    rd_ready   = 1'b0;
    store_strb = 1'b0;
    check({tag, "_end_busy"}, 32'(busy), 32'd0);
    check({tag, "_end_valid"}, 32'(rd_valid), 32'd0);
  endtask

  task automatic pulse_clr();
    @(negedge clk357);
    flags_clr = 1'b1;
    @(negedge clk357);
    flags_clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_rd_last"}, 32'(rd_last), 32'd0);
    check({tag, "_sample_count"}, 32'(sample_count), 32'd0);
    check({tag, "_trig_count"}, 32'(trig_count), 32'd0);
    check({tag, "_flags_busy"}, 32'({overflow, missed_trig, busy}), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk357);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk357);

    // -256 after correction, constant over 10 samples
    send_window(10, 1'b0, 13'h1F00);
    drain(10, 4'b1111, -1, "const");
    check("const_sample_count", 32'(sample_count), 32'd10);
    check("const_trig_count", 32'(trig_count), 32'd1);
    check("const_overflow", 32'(overflow), 32'd0);

    // 200-cycle window truncated to DEPTH
    send_window(200, 1'b1, 13'd0);
    drain(164, 4'b1111, -1, "ovf");
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_sample_count", 32'(sample_count), 32'd164);
    check("ovf_trig_count", 32'(trig_count), 32'd2);
    pulse_clr();
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Ramp drained under a 1,0,0,1 ready pattern
    send_window(32, 1'b1, 13'd0);
    drain(32, 4'b1001, -1, "stall");
    check("stall_trig_count", 32'(trig_count), 32'd3);
    check("stall_sample_count", 32'(sample_count), 32'd32);

    // New strobe five cycles into the drain must be ignored
    send_window(40, 1'b1, 13'd100);
    drain(40, 4'b1111, 5, "missed");
    check("missed_flag", 32'(missed_trig), 32'd1);
    check("missed_trig_count", 32'(trig_count), 32'd4);
    check("missed_sample_count", 32'(sample_count), 32'd40);
    check("missed_busy", 32'(busy), 32'd0);
    pulse_clr();
    check("missed_cleared", 32'(missed_trig), 32'd0);

    // Reset asserted halfway through a 100-sample window
    for (int i = 0; i < 50; i++) begin
      @(negedge clk357);
      store_strb = 1'b1;
      data_in    = 13'(i) ^ FLIP;
    end
    @(negedge clk357);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    store_strb = 1'b0;
    data_in    = '0;
    repeat (2) @(negedge clk357);
    rst_n = 1'b1;
    @(negedge clk357);
    send_window(8, 1'b1, 13'd7);
    drain(8, 4'b1111, -1, "postrst");
    check("postrst_trig_count", 32'(trig_count), 32'd1);
    check("postrst_sample_count", 32'(sample_count), 32'd8);

    // trig_count wrap
    @(negedge clk357);
    force dut.r_trig_count = 16'hFFFE;
    @(negedge clk357);
    release dut.r_trig_count;
    @(negedge clk357);
    check("wrap_preset", 32'(trig_count), 32'h0000FFFE);
    send_window(3, 1'b1, 13'd20);
    drain(3, 4'b1111, -1, "wrap1");
    check("wrap_ffff", 32'(trig_count), 32'h0000FFFF);
    send_window(3, 1'b1, 13'd30);
    drain(3, 4'b1111, -1, "wrap2");
    check("wrap_zero", 32'(trig_count), 32'h00000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
